// File: rtl/b14_viper_core.sv
// b14_viper_core: accumulator-style Viper subset core.
// Fetches a 31-bit instruction, optionally fetches a memory operand, then
// executes a compare, ALU, jump or store against reg0..reg2, the PC (reg3)
// and the condition flag B.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | drive PC onto addr with rd=1, drop any pending wr
//   LOAD   | latch IR from datai, bump PC, immediate or operand address
//   OPND   | latch memory operand m from datai
//   EXEC   | compare into B, or ALU result into register / PC / memory
module b14_viper_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [30:0] datai,
    output logic [19:0] addr,
    output logic [30:0] datao,
    output logic        rd,
    output logic        wr,
    input  logic        __obs
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_OPND  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [30:0] reg_q [4];
    logic [30:0] reg_d [4];
    logic [30:0] ir_q, ir_d;
    logic [30:0] m_q, m_d;
    logic        b_q, b_d;
    logic [19:0] addr_q, addr_d;
    logic [30:0] datao_q, datao_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic [30:0] r;
    logic [30:0] r_low;
    logic [30:0] y;
    logic        cond;

    // The debug observation input deliberately has no functional effect.
    logic unused_obs;
    assign unused_obs = __obs;

    // Operand / store address: tail alone, or tail indexed by reg1 / reg2.
    function automatic logic [19:0] eff_addr(input logic [1:0]  mf,
                                             input logic [18:0] tail,
                                             input logic [19:0] r1,
                                             input logic [19:0] r2);
        logic [19:0] base;
        base = {1'b0, tail};
        case (mf)
            2'd2:    eff_addr = base + r1;
            2'd3:    eff_addr = base + r2;
            default: eff_addr = base;
        endcase
    endfunction

    // Execute datapath: source operand, compare condition and ALU result.
    always_comb begin
        r     = reg_q[ir_q[30:29]];
        r_low = {1'b0, r[29:0]};
        cond  = 1'b0;
        y     = r;
        case (ir_q[21:19])
            3'd0: cond = (r < m_q);
            3'd1: cond = (r >= m_q);
            3'd2: cond = (r == m_q);
            3'd3: cond = (r != m_q);
            3'd4: cond = (r <= m_q);
            3'd5: cond = (r > m_q);
            3'd6: cond = (r_low < m_q);
            default: cond = (r_low >= m_q);
        endcase
        case (ir_q[22:19])
            4'd0:    y = m_q;
            4'd1:    y = r + m_q;
            4'd2:    y = r - m_q;
            4'd3:    y = r & m_q;
            4'd4:    y = r | m_q;
            4'd5:    y = r ^ m_q;
            4'd6:    y = ~m_q;
            4'd7:    y = {r[29:0], 1'b0};
            4'd8:    y = {1'b0, r[30:1]};
            4'd9:    y = m_q + 31'd1;
            default: y = r;
        endcase
    end

    // Sequencer: next state and next value of every architectural register.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        m_d     = m_q;
        b_d     = b_q;
        addr_d  = addr_q;
        datao_d = datao_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];

        case (state_q)
            S_FETCH: begin
                addr_d  = reg_q[3][19:0];
                rd_d    = 1'b1;
                wr_d    = 1'b0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ir_d     = datai;
                rd_d     = 1'b0;
                reg_d[3] = reg_q[3] + 31'd1;
                if (datai[28:27] == 2'd0) begin
                    m_d     = {12'd0, datai[18:0]};
                    state_d = S_EXEC;
                end else begin
                    addr_d  = eff_addr(datai[28:27], datai[18:0],
                                       reg_q[1][19:0], reg_q[2][19:0]);
                    rd_d    = 1'b1;
                    state_d = S_OPND;
                end
            end
            S_OPND: begin
                m_d     = datai;
                rd_d    = 1'b0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (ir_q[23]) begin
                    b_d = ir_q[22] ? (cond | b_q) : cond;
                end else begin
                    case (ir_q[26:24])
                        3'd0:    reg_d[0] = y;
                        3'd1:    reg_d[1] = y;
                        3'd2:    reg_d[2] = y;
                        3'd3:    reg_d[3] = y;
                        3'd4:    if (b_q)  reg_d[3] = y;
                        3'd5:    if (!b_q) reg_d[3] = y;
                        3'd6: begin
                            addr_d  = eff_addr(ir_q[28:27], ir_q[18:0],
                                               reg_q[1][19:0], reg_q[2][19:0]);
                            datao_d = r;
                            wr_d    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and register file update; reset aborts any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            m_q     <= '0;
            b_q     <= 1'b0;
            addr_q  <= '0;
            datao_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < 4; i++) reg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            datao_q <= datao_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
        end
    end

    assign addr  = addr_q;
    assign datao = datao_q;
    assign rd    = rd_q;
    assign wr    = wr_q;

endmodule

// File: tb/tb_b14_viper_core.sv
// Bench for b14_viper_core: a directed program with constant expectations,
// a reset-during-operand sequence, then random instructions checked
// against an instruction-level model of the Viper subset.
module tb_b14_viper_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        obs;
    logic [30:0] datai;
    logic [19:0] addr;
    logic [30:0] datao;
    logic        rd;
    logic        wr;

    b14_viper_core dut (
        .clock (clock),
        .reset (reset),
        .datai (datai),
        .addr  (addr),
        .datao (datao),
        .rd    (rd),
        .wr    (wr),
        .__obs (obs)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [30:0] ins;
        logic [30:0] opnd;
        int          cyc;
        logic [19:0] f_addr;
        logic [19:0] x_addr;
        logic [30:0] x_datao;
        logic        x_wr;
    } vec_t;

    vec_t vt[$];

    // instruction-level model state
    bit [30:0] mem [int];
    bit [30:0] mr [4];
    bit        mb;
    bit [30:0] md;

    function automatic bit [30:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : 31'd0;
    endfunction

    task automatic clk_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_bus(input string name, input logic [19:0] ea,
                             input logic [30:0] ed, input logic er, input logic ew);
        n_tests++;
        if (addr !== ea || datao !== ed || rd !== er || wr !== ew) begin
            n_fail++;
            $display("FAIL %s: got addr=%05h datao=%08h rd=%0b wr=%0b, want addr=%05h datao=%08h rd=%0b wr=%0b",
                     name, addr, datao, rd, wr, ea, ed, er, ew);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One random instruction: placed at the PC, run through the DUT and
    // checked cycle by cycle against the model.
    task automatic rand_instr(input int k);
        bit [30:0] ins, r, m, y, rc;
        bit [1:0]  s, mf;
        bit [2:0]  df;
        bit        cf, c;
        bit [3:0]  ff;
        bit [19:0] pc20, tl, oa, ea, last;
        bit        st;
        ins  = 31'($urandom);
        s    = ins[30:29];
        mf   = ins[28:27];
        df   = ins[26:24];
        cf   = ins[23];
        ff   = ins[22:19];
        tl   = {1'b0, ins[18:0]};
        pc20 = mr[3][19:0];
        case (mf)
            2'd2:    oa = tl + mr[1][19:0];
            2'd3:    oa = tl + mr[2][19:0];
            default: oa = tl;
        endcase
        if (mf != 2'd0 && !mem.exists(int'(oa))) mem[int'(oa)] = 31'($urandom);
        mem[int'(pc20)] = ins;
        obs = 1'($urandom);

        clk_edge();
        check_bus($sformatf("rnd%0d_fetch", k), pc20, md, 1'b1, 1'b0);
        datai = mem_rd(int'(addr));
        mr[3] = mr[3] + 31'd1;

        clk_edge();
        if (mf == 2'd0) begin
            check_bus($sformatf("rnd%0d_load", k), pc20, md, 1'b0, 1'b0);
            last = pc20;
            m    = {12'd0, ins[18:0]};
        end else begin
            check_bus($sformatf("rnd%0d_load", k), oa, md, 1'b1, 1'b0);
            datai = mem_rd(int'(addr));
            clk_edge();
            check_bus($sformatf("rnd%0d_opnd", k), oa, md, 1'b0, 1'b0);
            last = oa;
            m    = mem_rd(int'(oa));
        end

        r  = mr[s];
        rc = r & 31'h3FFF_FFFF;
        st = 1'b0;
        if (cf) begin
            case (ff[2:0])
                3'd0: c = r < m;
                3'd1: c = r >= m;
                3'd2: c = r == m;
                3'd3: c = r != m;
                3'd4: c = r <= m;
                3'd5: c = r > m;
                3'd6: c = rc < m;
                default: c = rc >= m;
            endcase
            mb = ff[3] ? (c | mb) : c;
        end else begin
            case (ff)
                4'd0: y = m;
                4'd1: y = r + m;
                4'd2: y = r - m;
                4'd3: y = r & m;
                4'd4: y = r | m;
                4'd5: y = r ^ m;
                4'd6: y = ~m;
                4'd7: y = r << 1;
                4'd8: y = r >> 1;
                4'd9: y = m + 31'd1;
                default: y = r;
            endcase
            if (df <= 3'd3) mr[df[1:0]] = y;
            else if (df == 3'd4 && mb) mr[3] = y;
            else if (df == 3'd5 && !mb) mr[3] = y;
            else if (df == 3'd6) begin
                ea = (mf == 2'd0) ? tl : oa;
                md = r;
                mem[int'(ea)] = r;
                last = ea;
                st = 1'b1;
            end
        end

        clk_edge();
        check_bus($sformatf("rnd%0d_exec", k), last, md, 1'b0, st);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [30:0] prev_d;

        //        ins           opnd          cyc f_addr    x_addr    x_datao       x_wr
        vt.push_back('{31'h00000005, 31'h0,        3, 20'h00000, 20'h00000, 31'h00000000, 1'b0});
        vt.push_back('{31'h06000100, 31'h0,        3, 20'h00001, 20'h00100, 31'h00000005, 1'b1});
        vt.push_back('{31'h00800007, 31'h0,        3, 20'h00002, 20'h00002, 31'h00000005, 1'b0});
        vt.push_back('{31'h04000020, 31'h0,        3, 20'h00003, 20'h00003, 31'h00000005, 1'b0});
        vt.push_back('{31'h01000010, 31'h0,        3, 20'h00020, 20'h00020, 31'h00000005, 1'b0});
        vt.push_back('{31'h10000004, 31'h00001234, 4, 20'h00021, 20'h00014, 31'h00000005, 1'b0});
        vt.push_back('{31'h06000101, 31'h0,        3, 20'h00022, 20'h00101, 31'h00001234, 1'b1});
        vt.push_back('{31'h00800007, 31'h0,        3, 20'h00023, 20'h00023, 31'h00001234, 1'b0});
        vt.push_back('{31'h04000040, 31'h0,        3, 20'h00024, 20'h00024, 31'h00001234, 1'b0});
        vt.push_back('{31'h05000040, 31'h0,        3, 20'h00025, 20'h00025, 31'h00001234, 1'b0});
        vt.push_back('{31'h66000200, 31'h0,        3, 20'h00040, 20'h00200, 31'h00000041, 1'b1});
        vt.push_back('{31'h00101235, 31'h0,        3, 20'h00041, 20'h00041, 31'h00000041, 1'b0});
        vt.push_back('{31'h06000202, 31'h0,        3, 20'h00042, 20'h00202, 31'h7FFFFFFF, 1'b1});
        vt.push_back('{31'h00B80005, 31'h0,        3, 20'h00043, 20'h00043, 31'h7FFFFFFF, 1'b0});
        vt.push_back('{31'h04000050, 31'h0,        3, 20'h00044, 20'h00044, 31'h7FFFFFFF, 1'b0});
        vt.push_back('{31'h0A000300, 31'h000055AA, 4, 20'h00050, 20'h00300, 31'h7FFFFFFF, 1'b0});
        vt.push_back('{31'h5E000010, 31'h0,        4, 20'h00051, 20'h055BA, 31'h000055AA, 1'b1});
        vt.push_back('{31'h00C00005, 31'h0,        3, 20'h00052, 20'h00052, 31'h000055AA, 1'b0});
        vt.push_back('{31'h05000070, 31'h0,        3, 20'h00053, 20'h00053, 31'h000055AA, 1'b0});
        vt.push_back('{31'h04000070, 31'h0,        3, 20'h00054, 20'h00054, 31'h000055AA, 1'b0});
        vt.push_back('{31'h07000000, 31'h0,        3, 20'h00070, 20'h00070, 31'h000055AA, 1'b0});

        reset = 1'b0;
        obs   = 1'b0;
        datai = 31'h0;
        repeat (3) clk_edge();
        check_bus("reset_state", 20'h0, 31'h0, 1'b0, 1'b0);
        reset = 1'b1;
        check_bus("reset_release", 20'h0, 31'h0, 1'b0, 1'b0);

        prev_d = 31'h0;
        foreach (vt[i]) begin
            clk_edge();
            check_bus($sformatf("v%0d_fetch", i), vt[i].f_addr, prev_d, 1'b1, 1'b0);
            datai = vt[i].ins;
            clk_edge();
            cyc = 2;
            if (rd) begin
                datai = vt[i].opnd;
                clk_edge();
                cyc++;
            end
            clk_edge();
            cyc++;
            check_int($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            check_bus($sformatf("v%0d_exec", i), vt[i].x_addr, vt[i].x_datao, 1'b0, vt[i].x_wr);
            prev_d = vt[i].x_datao;
        end

        // reset pulsed while the operand read is outstanding
        clk_edge();
        check_bus("abort_fetch", 20'h00071, 31'h000055AA, 1'b1, 1'b0);
        datai = 31'h08000123;
        clk_edge();
        check_bus("abort_opnd_rd", 20'h00123, 31'h000055AA, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_bus("abort_async", 20'h0, 31'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            obs = ~obs;
            clk_edge();
            check_bus($sformatf("abort_hold%0d", i), 20'h0, 31'h0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        obs   = ~obs;
        clk_edge();
        check_bus("abort_refetch", 20'h0, 31'h0, 1'b1, 1'b0);

        // clean start for the random phase
        reset = 1'b0;
        clk_edge();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) mr[i] = 31'h0;
        mb = 1'b0;
        md = 31'h0;
        for (int k = 0; k < 300; k++) rand_instr(k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/b14_viper_core.md
Name: b14_viper_core

Overview:
- Small accumulator-style processor core (Viper subset) for benchmark and test-generation use; sits between a single-ported word memory and the test harness.
- Fetches 31-bit instructions over a 20-bit address bus and executes them against four 31-bit registers (reg3 is the PC) and a 1-bit condition flag B.
- Executes compare, ALU, conditional-jump and store operations; one instruction takes 3 or 4 cycles.

Parameters:
- None (all widths fixed: data 31, address 20).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- datai  input  31  memory read data; sampled at rising edges in LOAD and OPND states.
- addr  output  20  memory address, registered.
- datao  output  31  memory write data, registered.
- rd  output  1  read strobe, registered.
- wr  output  1  write strobe, registered, exactly one cycle per store.
- __obs  input  1  observation/debug input; has no functional effect on any output or state.

Behaviour:
- Reset (reset=0, asynchronous):
  - addr=0, datao=0, rd=0, wr=0.
  - reg0..reg3=0, B=0, IR=0, m=0.
  - state=FETCH.
- Instruction fields (IR[30:0]):
  - s=IR[30:29] source register select.
  - mf=IR[28:27] operand mode.
  - df=IR[26:24] destination.
  - cf=IR[23] compare flag.
  - ff=IR[22:19] function.
  - tail=IR[18:0], zero-extended.
- States: FETCH -> LOAD -> [OPND] -> EXEC -> FETCH.
- FETCH: addr<=reg3[19:0]; rd<=1; wr<=0.
- LOAD:
  - IR<=datai; rd<=0; reg3<=reg3+1 (mod 2^31).
  - mf=0: m<=tail, next EXEC.
  - mf=1: addr<=tail.
  - mf=2: addr<=(tail+reg1) mod 2^20.
  - mf=3: addr<=(tail+reg2) mod 2^20.
  - mf!=0: rd<=1, next OPND.
  - Decode uses datai directly in this cycle.
- OPND: m<=datai; rd<=0; next EXEC.
- EXEC: r = reg[s]. For s=3, r is the already-incremented PC.
- cf=1 (compare): unsigned compare, updates B only; df is ignored.
  - Base condition c by ff[2:0]:
    - 0: r<m
    - 1: r>=m
    - 2: r==m
    - 3: r!=m
    - 4: r<=m
    - 5: r>m
    - 6: (r with bit30 cleared)<m
    - 7: (r with bit30 cleared)>=m
  - B <= ff[3] ? (c | B) : c.
- cf=0 (ALU): result y by ff:
  - 0: m
  - 1: r+m
  - 2: r-m
  - 3: r&m
  - 4: r|m
  - 5: r^m
  - 6: ~m
  - 7: r<<1
  - 8: r>>1 (logical)
  - 9: m+1
  - 10-15: r
  - All arithmetic is mod 2^31; no flags.
- Destination for cf=0, by df:
  - 0-2: reg[df]<=y.
  - 3: reg3<=y (jump).
  - 4: reg3<=y if B=1.
  - 5: reg3<=y if B=0.
  - 6: store; addr<=effective address (tail for mf=0, else as in LOAD), datao<=r, wr<=1. wr is cleared in the following FETCH.
  - 7: no-op.
- Addresses wrap mod 2^20; the PC register wraps mod 2^31 and only bits [19:0] drive addr.
- datao holds its last stored value until the next store.
- rd and wr are never both 1.
- Reset asserted mid-instruction aborts it immediately; registers return to reset values.

Test Plan:
- Reset then release -> addr=0x00000, rd=0, wr=0. First FETCH edge gives addr=0, rd=1. The LOAD edge gives rd=0 and PC=1.
- datai=0x00000005 at LOAD (move imm 5 to reg0) -> reg0=5; next FETCH addr=0x00001; 3 cycles per instruction.
- Store reg0: 0x06000100 -> addr=0x00100, datao=5, wr=1 for exactly one cycle; next cycle wr=0, addr=0x00002.
- Compare reg0(5) < imm 7: 0x00800007 -> B=1, no register change.
- Conditional jump: 0x04000020 (df=4, B=1) -> next fetch addr=0x00020. With B=0, fetch continues sequentially.
- Memory operand, reg1=0x10: 0x10000004 (mf=2, ff=0, df=0) -> addr=0x00014 with rd=1 in OPND; datai=0x1234 loads reg0=0x1234; 4 cycles total.
- Reset pulsed low during OPND -> all outputs 0 and state FETCH; __obs toggling changes nothing.
